// File: rtl/light_load_ctrl_pkg.sv
// rtl/light_load_ctrl_pkg.sv - shared opcodes, record layout and state encoding for the light loader
package light_load_ctrl_pkg;

  localparam logic [3:0] OP_WRITE_LIGHT = 4'h1;
  localparam logic [3:0] OP_COMMIT      = 4'h2;
  localparam int         FORCE_BIT      = 27;

  localparam int REC_WORDS = 6;
  localparam int REC_W     = 32 * REC_WORDS;
  localparam int L2_W      = 289;

  // Record field offsets; every field is one Q8.24 word.
  localparam int POS_X_LSB = 0;
  localparam int POS_Y_LSB = 32;
  localparam int POS_Z_LSB = 64;
  localparam int COL_R_LSB = 96;
  localparam int COL_G_LSB = 128;
  localparam int COL_B_LSB = 160;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD        = 3'd1,
    ST_WRITE       = 3'd2,
    ST_COMMIT_WAIT = 3'd3,
    ST_FLUSH       = 3'd4
  } state_t;

  function automatic int word_lsb(input logic [2:0] k);
    return 32 * int'(k);
  endfunction

endpackage

// File: rtl/light_load_ctrl_if.sv
// rtl/light_load_ctrl_if.sv - host word stream, frame sync and light store staging port
interface light_load_ctrl_if;
  import light_load_ctrl_pkg::*;

  logic [31:0]     in_data;
  logic            in_valid;
  logic            in_ready;
  logic            frame_start;
  logic            l2_write_enable;
  logic [2:0]      l2_write_id;
  logic [L2_W-1:0] l2_write;
  logic            l2_flush_to_l1;
  logic            busy;
  logic            cmd_error;

  modport master (
    output in_data, in_valid, frame_start,
    input  in_ready, l2_write_enable, l2_write_id, l2_write,
    input  l2_flush_to_l1, busy, cmd_error
  );

  modport slave (
    input  in_data, in_valid, frame_start,
    output in_ready, l2_write_enable, l2_write_id, l2_write,
    output l2_flush_to_l1, busy, cmd_error
  );

endinterface

// File: rtl/light_load_ctrl.sv
// rtl/light_load_ctrl.sv - parses host light packets into staging writes and frame-synced flushes
module light_load_ctrl
  import light_load_ctrl_pkg::*;
#(
  parameter int NUM_LIGHTS  = 8,
  parameter int FLUSH_GUARD = 18
) (
  input logic             clk,
  input logic             rst,
  light_load_ctrl_if.slave bus
);

  localparam int         GW        = $clog2(FLUSH_GUARD + 1);
  localparam logic [2:0] LAST_WORD = 3'(REC_WORDS - 1);

  state_t           state;
  logic [2:0]       word_cnt;
  logic [GW-1:0]    guard_cnt;
  logic             in_ready_q;
  logic             we_q;
  logic             flush_q;
  logic             err_q;
  logic [2:0]       id_q;
  logic [REC_W-1:0] rec_q;

  logic       accept;
  logic [3:0] opcode;

  assign accept = bus.in_valid && in_ready_q;
  assign opcode = bus.in_data[31:28];

  assign bus.in_ready        = in_ready_q;
  assign bus.l2_write_enable = we_q;
  assign bus.l2_flush_to_l1  = flush_q;
  assign bus.cmd_error       = err_q;
  assign bus.l2_write_id     = id_q;
  assign bus.l2_write        = {{(L2_W - REC_W){1'b0}}, rec_q};
  assign bus.busy            = (state != ST_IDLE);

  // in_ready is a registered copy of "state accepts words", so it reads 0 right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      guard_cnt  <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      id_q       <= '0;
      rec_q      <= '0;
    end else begin
      we_q    <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (opcode == OP_WRITE_LIGHT && int'(bus.in_data[2:0]) < NUM_LIGHTS) begin
              state    <= ST_LOAD;
              id_q     <= bus.in_data[2:0];
              word_cnt <= '0;
            end else if (opcode == OP_COMMIT) begin
              in_ready_q <= 1'b0;
              if (bus.in_data[FORCE_BIT]) begin
                state     <= ST_FLUSH;
                flush_q   <= 1'b1;
                guard_cnt <= '0;
              end else begin
                state <= ST_COMMIT_WAIT;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            rec_q[word_lsb(word_cnt) +: 32] <= bus.in_data;
            if (word_cnt == LAST_WORD) begin
              state      <= ST_WRITE;
              we_q       <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              word_cnt <= word_cnt + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          state      <= ST_IDLE;
          word_cnt   <= '0;
          in_ready_q <= 1'b1;
        end
        ST_COMMIT_WAIT: begin
          if (bus.frame_start) begin
            state     <= ST_FLUSH;
            flush_q   <= 1'b1;
            guard_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          // Guard spans the copy window so no staging write lands mid-copy.
          if (guard_cnt == GW'(FLUSH_GUARD - 1)) begin
            state      <= ST_IDLE;
            in_ready_q <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_load_ctrl.sv
// tb/tb_light_load_ctrl.sv - scoreboard bench for light_load_ctrl
module tb_light_load_ctrl;

  localparam int K_WR  = 0;
  localparam int K_ERR = 1;
  localparam int K_FL  = 2;

  typedef struct {
    int           kind;
    int           cyc;
    logic [2:0]   id;
    logic [191:0] rec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_acc = 0;
  exp_t sb[$];

  light_load_ctrl_if bus();

  light_load_ctrl #(.NUM_LIGHTS(8), .FLUSH_GUARD(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [288:0] act, input logic [288:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int c, input logic [2:0] id, input logic [191:0] rec);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.id   = id;
    e.rec  = rec;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == K_WR) begin
        check("write_id", bus.l2_write_id, e.id);
        check("write_data", bus.l2_write, {97'b0, e.rec});
      end
    end
  endtask

  // Monitor: every output strobe must match the head of the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (bus.l2_write_enable) pop_check(K_WR);
      if (bus.cmd_error)       pop_check(K_ERR);
      if (bus.l2_flush_to_l1)  pop_check(K_FL);
    end
  end

  task automatic send(input logic [31:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready %b after %0d cycles, required 1", bus.in_ready, t);
    end
    @(negedge clk);
    last_acc     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [2:0] id, input logic [191:0] rec, input bit gaps);
    for (int k = 0; k < 6; k++) begin
      if (gaps) repeat ($urandom_range(3, 0)) @(negedge clk);
      send(rec[32*k +: 32]);
    end
    expect_ev(K_WR, last_acc, id, rec);
  endtask

  task automatic send_packet(input logic [2:0] id, input logic [191:0] rec, input bit gaps);
    send({4'h1, 25'h0, id});
    send_payload(id, rec, gaps);
  endtask

  logic [191:0] rec1, rec2, rec3, rec4, rec5, rec6;
  int a;

  initial begin
    rec1 = {32'h01000000, 32'h01000000, 32'h01000000, 32'h00000000, 32'h03000000, 32'h00000000};
    rec2 = {32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hA5A5A5A5};
    rec3 = {32'h00FF00FF, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h33333333, 32'hCCCCCCCC};
    rec4 = {32'h06000006, 32'h05000005, 32'h04000004, 32'h03000003, 32'h02000002, 32'h01000001};
    rec5 = {32'h7FFFFFFF, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 32'h01234567, 32'h89ABCDEF};
    rec6 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.frame_start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_we", bus.l2_write_enable, 0);
    check("rst_flush", bus.l2_flush_to_l1, 0);
    check("rst_err", bus.cmd_error, 0);
    check("rst_id", bus.l2_write_id, 0);
    check("rst_data", bus.l2_write, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic light write; write strobe cycle shows in_ready low.
    send_packet(3'd1, rec1, 1'b0);
    check("write_in_ready", bus.in_ready, 0);
    check("write_busy", bus.busy, 1);

    // Commit with frame_start coincident with the header (ignored), then a real pulse.
    bus.frame_start = 1'b1;
    send(32'h20000000);
    bus.frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("cwait_in_ready", bus.in_ready, 0);
      check("cwait_busy", bus.busy, 1);
      @(negedge clk);
    end
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    expect_ev(K_FL, cyc, 3'd0, '0);
    for (int i = 0; i < 18; i++) begin
      bus.frame_start = (i == 3);
      check("flush_busy", bus.busy, 1);
      check("flush_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.frame_start = 1'b0;
    check("post_flush_busy", bus.busy, 0);
    check("post_flush_in_ready", bus.in_ready, 1);

    // frame_start in IDLE is ignored.
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_frame_busy", bus.busy, 0);

    // Force commit, then a WRITE_LIGHT header held until the guard expires.
    send(32'h28000000);
    a = last_acc;
    expect_ev(K_FL, a, 3'd0, '0);
    send(32'h10000002);
    check("flush_guard_gap", last_acc - a, 19);
    send_payload(3'd2, rec2, 1'b0);

    // Illegal opcodes, then a normal packet.
    @(negedge clk);
    send(32'h50000000);
    expect_ev(K_ERR, last_acc, 3'd0, '0);
    @(negedge clk);
    send(32'h00000000);
    expect_ev(K_ERR, last_acc, 3'd0, '0);
    @(negedge clk);
    send(32'hF0000003);
    expect_ev(K_ERR, last_acc, 3'd0, '0);
    @(negedge clk);
    check("err_busy", bus.busy, 0);
    send_packet(3'd3, rec3, 1'b0);

    // Reset after three payload words discards the partial record.
    send(32'h10000004);
    for (int k = 0; k < 3; k++) send(32'hBAD00000 + k);
    rst = 1'b1;
    @(negedge clk);
    check("midload_rst_data", bus.l2_write, 0);
    check("midload_rst_id", bus.l2_write_id, 0);
    check("midload_rst_busy", bus.busy, 0);
    check("midload_rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    send_packet(3'd4, rec4, 1'b0);

    // Stalled payload words produce the same record.
    send_packet(3'd5, rec1, 1'b1);
    send_packet(3'd7, rec5, 1'b1);

    // Reset mid-FLUSH aborts the guard with no second pulse.
    send(32'h28000000);
    expect_ev(K_FL, last_acc, 3'd0, '0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midflush_rst_busy", bus.busy, 0);
    send_packet(3'd6, rec6, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/light_load_ctrl.md
LIGHT_LOAD_CTRL -- requirements
Module: light_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_LIGHTS, default 8, meaning number of light slots addressable.
REQ-002 SHALL have parameter FLUSH_GUARD, default 18, meaning the number of cycles held in FLUSH, counted from and including the flush-pulse cycle.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  32  command/payload word from host.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  word accepted when in_valid && in_ready.
REQ-008 frame_start  input  1  one-cycle pulse from renderer at frame boundary.
REQ-009 l2_write_enable  output  1  write strobe to light store staging bank.
REQ-010 l2_write_id  output  3  target light slot.
REQ-011 l2_write  output  289  light record; bits [191:0] are the record, bits [288:192] are 0.
REQ-012 l2_flush_to_l1  output  1  one-cycle pulse starting staging-to-active copy.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 cmd_error  output  1  one-cycle pulse on an illegal header.

Function
REQ-015 SHALL implement states IDLE, LOAD, WRITE, COMMIT_WAIT, FLUSH.
REQ-016 IDLE: in_ready=1; the accepted word is a header; opcode = in_data[31:28].
REQ-017 Opcode 0x1 (WRITE_LIGHT): latch id = in_data[2:0] and go to LOAD with word counter 0.
REQ-018 Opcode 0x2 (COMMIT): if in_data[27]=1 (force), go to FLUSH; otherwise go to COMMIT_WAIT.
REQ-019 Any other opcode, or WRITE_LIGHT with id >= NUM_LIGHTS: pulse cmd_error the next cycle and stay in IDLE.
REQ-020 LOAD: in_ready=1; accepted word k (0..5) is stored at record bits [32k+31:32k]: k=0..2 are pos x,y,z; k=3..5 are col r,g,b, all Q8.24.
REQ-021 After word 5 is accepted, go to WRITE; in_valid low stalls LOAD indefinitely with no timeout.
REQ-022 WRITE: in_ready=0; l2_write_enable=1 for exactly one cycle with l2_write_id and l2_write stable; then return to IDLE.
REQ-023 COMMIT_WAIT: in_ready=0; on the first cycle frame_start=1 is sampled, go to FLUSH.
REQ-024 A frame_start pulse in the same cycle the COMMIT header is accepted SHALL NOT count.
REQ-025 FLUSH: l2_flush_to_l1=1 only in the first FLUSH cycle; in_ready=0 and l2_write_enable=0 for all FLUSH_GUARD cycles; then go to IDLE.
REQ-026 FLUSH ensures no staging write overlaps the 16-cycle copy, because the light store takes 2 cycles per slot.
REQ-027 Outputs l2_write_enable, l2_flush_to_l1 and cmd_error SHALL be registered, with no combinational path from inputs.
REQ-028 in_ready SHALL be a function of state only.
REQ-029 frame_start outside COMMIT_WAIT SHALL be ignored.
REQ-030 Accepted-word to l2_write_enable latency SHALL be 1 cycle after the sixth payload word.
REQ-031 Force-commit header acceptance to l2_flush_to_l1 latency SHALL be 1 cycle.

Reset
REQ-032 On rst: state=IDLE, word counter=0, in_ready=0 during the rst cycle, and l2_write_enable=l2_flush_to_l1=cmd_error=busy=0.
REQ-033 On rst, l2_write_id=0 and l2_write=0.
REQ-034 rst mid-LOAD SHALL discard the partial record with no write issued; rst mid-FLUSH SHALL abort the guard and issue no second pulse.

Structure
REQ-035 A shared package SHALL hold the opcode constants (OP_WRITE_LIGHT=4'h1, OP_COMMIT=4'h2), the record field offsets, and the state encoding.
REQ-036 The block SHALL be a single module with no sub-modules; the guard counter and word counter are inline.

Verification
REQ-037 Header 0x10000001, then words 0,0x03000000,0,0x01000000,0x01000000,0x01000000 -> one l2_write_enable with id=1 and l2_write[191:0] matching, 1 cycle after the last word.
REQ-038 Header 0x20000000, frame_start pulsed 5 cycles later -> l2_flush_to_l1 1 cycle after frame_start; busy high for 18 cycles after; in_ready=0 throughout.
REQ-039 Header 0x28000000 with frame_start low -> flush pulse the next cycle; a following WRITE_LIGHT header is not accepted until FLUSH_GUARD cycles have elapsed.
REQ-040 Header 0x50000000 -> cmd_error single pulse, no write; next valid header accepted normally.
REQ-041 rst asserted after 3 payload words -> no write; a fresh full packet afterwards writes correctly.
REQ-042 in_valid toggled randomly during LOAD -> same record written as with back-to-back words.
